// File: rtl/wb_stage.sv
// Writeback stage: register file, condition codes, branch resolution and redirect.
// Define WB_PERF_CNT_EN to build in the retired/mispredict performance counters.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        stall,
  input  logic        load_regfile,
  input  logic        load_cc,
  input  logic        is_br,
  input  logic        brpredict,
  input  logic [1:0]  wbmux_sel,
  input  logic [15:0] alu_out,
  input  logic [15:0] mem_data,
  input  logic [15:0] pc_out,
  input  logic [15:0] intr,
  input  logic [2:0]  destreg,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  output logic [15:0] sr1_out,
  output logic [15:0] sr2_out,
  output logic [2:0]  cc_out,
  output logic        wb_we,
  output logic [2:0]  wb_destreg,
  output logic [15:0] wb_data,
  output logic        flush,
  output logic [15:0] redirect_pc,
  output logic [31:0] retired_cnt,
  output logic [15:0] mispredict_cnt
);

  logic [15:0] regfile_q [8];
  logic [2:0]  cc_q, cc_d;
  logic        flush_q, flush_d;
  logic [15:0] redirect_q, redirect_d;
  logic        commit;
  logic        taken;
  logic        mispredict;
  logic [15:0] target;
  logic        intr_unused;

  assign intr_unused = ^{intr[15:12], intr[8:0]};

  always_comb begin
    wb_data = 16'h0000;
    unique case (wbmux_sel)
      2'd0: wb_data = alu_out;
      2'd1: wb_data = mem_data;
      2'd2: wb_data = pc_out;
      2'd3: wb_data = 16'h0000;
    endcase
  end

  assign commit     = valid & stall;
  assign wb_we      = commit & load_regfile;
  assign wb_destreg = destreg;

  // Write-through bypass so decode sees the value committing this cycle.
  assign sr1_out = (wb_we && (sr1 == destreg)) ? wb_data : regfile_q[sr1];
  assign sr2_out = (wb_we && (sr2 == destreg)) ? wb_data : regfile_q[sr2];

  assign taken      = |(intr[11:9] & cc_q);
  assign mispredict = commit & is_br & (taken != brpredict);
  assign target     = taken ? alu_out : pc_out;

  always_comb begin
    cc_d = cc_q;
    if (commit && load_cc) begin
      if (wb_data[15])
        cc_d = 3'b100;
      else if (wb_data == 16'h0000)
        cc_d = 3'b010;
      else
        cc_d = 3'b001;
    end
    flush_d    = mispredict;
    redirect_d = mispredict ? target : redirect_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regfile_q[i] <= 16'h0000;
      cc_q       <= 3'b010;
      flush_q    <= 1'b0;
      redirect_q <= 16'h0000;
    end else begin
      if (wb_we) regfile_q[destreg] <= wb_data;
      cc_q       <= cc_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  // A reset landing in the flush cycle kills the pending redirect immediately.
  assign flush       = flush_q & ~reset;
  assign cc_out      = cc_q;
  assign redirect_pc = redirect_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [15:0] mispred_q, mispred_d;

  always_comb begin
    retired_d = commit ? retired_q + 32'd1 : retired_q;
    mispred_d = (mispredict && (mispred_q != 16'hFFFF)) ? mispred_q + 16'd1 : mispred_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'd0;
      mispred_q <= 16'd0;
    end else begin
      retired_q <= retired_d;
      mispred_q <= mispred_d;
    end
  end

  assign retired_cnt    = retired_q;
  assign mispredict_cnt = mispred_q;
`else
  assign retired_cnt    = 32'd0;
  assign mispredict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (counter expectations follow WB_PERF_CNT_EN).
module tb_wb_stage;

`ifdef WB_PERF_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, valid, stall, loadRegfile, loadCc, isBr, brPredict;
  logic [1:0]  wbmuxSel;
  logic [15:0] aluOut, memData, pcOut, intr;
  logic [2:0]  destReg, sr1, sr2;
  logic [15:0] sr1Out, sr2Out, wbData, redirectPc, mispredictCnt;
  logic [2:0]  ccOut, wbDestReg;
  logic        wbWe, flush;
  logic [31:0] retiredCnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .valid(valid), .stall(stall),
    .load_regfile(loadRegfile), .load_cc(loadCc), .is_br(isBr), .brpredict(brPredict),
    .wbmux_sel(wbmuxSel), .alu_out(aluOut), .mem_data(memData), .pc_out(pcOut),
    .intr(intr), .destreg(destReg), .sr1(sr1), .sr2(sr2),
    .sr1_out(sr1Out), .sr2_out(sr2Out), .cc_out(ccOut),
    .wb_we(wbWe), .wb_destreg(wbDestReg), .wb_data(wbData),
    .flush(flush), .redirect_pc(redirectPc),
    .retired_cnt(retiredCnt), .mispredict_cnt(mispredictCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    reset = 1'b0; valid = 1'b0; stall = 1'b1; loadRegfile = 1'b0; loadCc = 1'b0;
    isBr = 1'b0; brPredict = 1'b0; wbmuxSel = 2'd0; aluOut = '0; memData = '0;
    pcOut = '0; intr = '0; destReg = '0; sr1 = '0; sr2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_cc", 32'(ccOut), 32'h2);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_redirect", 32'(redirectPc), 32'h0);
    checkOutput("rst_retired", retiredCnt, 32'h0);
    checkOutput("rst_mispred", 32'(mispredictCnt), 32'h0);

    // regfile write of mem_data with same-cycle bypass
    valid = 1; loadRegfile = 1; destReg = 3; wbmuxSel = 2'd1; memData = 16'h8001; sr1 = 3;
    #1;
    checkOutput("byp_sr1", 32'(sr1Out), 32'h8001);
    checkOutput("byp_we", 32'(wbWe), 32'h1);
    checkOutput("byp_dest", 32'(wbDestReg), 32'h3);
    tick();
    applyStimulus(); sr1 = 3;
    #1;
    checkOutput("r3_after", 32'(sr1Out), 32'h8001);

    valid = 1; loadRegfile = 1; destReg = 5; wbmuxSel = 2'd0; aluOut = 16'h1234;
    tick();
    applyStimulus(); sr2 = 5; wbmuxSel = 2'd2; pcOut = 16'h0102; memData = 16'hAAAA;
    #1;
    checkOutput("r5_sr2", 32'(sr2Out), 32'h1234);
    checkOutput("mux_pc", 32'(wbData), 32'h0102);
    checkOutput("idle_we", 32'(wbWe), 32'h0);
    wbmuxSel = 2'd3; aluOut = 16'h5555;
    #1;
    checkOutput("mux_zero", 32'(wbData), 32'h0);

    // condition codes
    applyStimulus(); valid = 1; loadCc = 1; aluOut = 16'h0000;
    tick();
    checkOutput("cc_zero", 32'(ccOut), 32'h2);
    aluOut = 16'hFFFE;
    tick();
    checkOutput("cc_neg", 32'(ccOut), 32'h4);
    aluOut = 16'h0005;
    tick();
    checkOutput("cc_pos", 32'(ccOut), 32'h1);

    // stall hold: nothing may change
    applyStimulus(); valid = 1; stall = 0; loadRegfile = 1; destReg = 5; aluOut = 16'hBEEF;
    loadCc = 1; isBr = 1; brPredict = 1; intr = 16'h0000; sr2 = 5;
    #1;
    checkOutput("stall_we", 32'(wbWe), 32'h0);
    tick();
    checkOutput("stall_r5", 32'(sr2Out), 32'h1234);
    checkOutput("stall_flush", 32'(flush), 32'h0);
    checkOutput("stall_cc", 32'(ccOut), 32'h1);
    checkOutput("stall_retired", retiredCnt, CntEn ? 32'd5 : 32'd0);

    // valid=0 entries ignored
    valid = 0; stall = 1;
    tick();
    checkOutput("inv_r5", 32'(sr2Out), 32'h1234);
    checkOutput("inv_flush", 32'(flush), 32'h0);
    checkOutput("inv_cc", 32'(ccOut), 32'h1);

    // mispredict: cc=010, intr[11:9]=010, predicted not-taken
    applyStimulus(); valid = 1; loadCc = 1; aluOut = 16'h0000;
    tick();
    applyStimulus(); valid = 1; isBr = 1; intr = 16'h0400; brPredict = 0;
    aluOut = 16'h0040; pcOut = 16'h0102;
    tick();
    checkOutput("mp_flush", 32'(flush), 32'h1);
    checkOutput("mp_redirect", 32'(redirectPc), 32'h0040);
    applyStimulus();
    tick();
    checkOutput("mp_flush_off", 32'(flush), 32'h0);
    checkOutput("mp_redirect_hold", 32'(redirectPc), 32'h0040);

    // correctly predicted not-taken branch
    valid = 1; isBr = 1; intr = 16'h0800; brPredict = 0; aluOut = 16'h0777; pcOut = 16'h0300;
    tick();
    checkOutput("okbr_flush", 32'(flush), 32'h0);
    checkOutput("okbr_redirect", 32'(redirectPc), 32'h0040);

    // back-to-back mispredicts
    brPredict = 1; intr = 16'h0800; pcOut = 16'h0202; aluOut = 16'h0999;
    tick();
    checkOutput("b2b1_flush", 32'(flush), 32'h1);
    checkOutput("b2b1_redirect", 32'(redirectPc), 32'h0202);
    brPredict = 0; intr = 16'h0400; aluOut = 16'h0080; pcOut = 16'h0404;
    tick();
    checkOutput("b2b2_flush", 32'(flush), 32'h1);
    checkOutput("b2b2_redirect", 32'(redirectPc), 32'h0080);
    applyStimulus();
    tick();
    checkOutput("b2b_off", 32'(flush), 32'h0);
    checkOutput("cnt_retired", retiredCnt, CntEn ? 32'd10 : 32'd0);
    checkOutput("cnt_mispred", 32'(mispredictCnt), CntEn ? 32'd3 : 32'd0);

    // reset the cycle after a mispredict commit, with a commit on the reset edge
    valid = 1; isBr = 1; intr = 16'h0400; brPredict = 0; aluOut = 16'h0123;
    tick();
    checkOutput("pre_rst_flush", 32'(flush), 32'h1);
    reset = 1; valid = 1; isBr = 1; intr = 16'h0400; brPredict = 0; aluOut = 16'h0321;
    loadRegfile = 1; destReg = 2; loadCc = 1; wbmuxSel = 2'd0;
    #1;
    checkOutput("rst_kill_flush", 32'(flush), 32'h0);
    tick();
    applyStimulus();
    #1;
    checkOutput("mid_rst_flush", 32'(flush), 32'h0);
    checkOutput("mid_rst_cc", 32'(ccOut), 32'h2);
    checkOutput("mid_rst_redirect", 32'(redirectPc), 32'h0);
    checkOutput("mid_rst_retired", retiredCnt, 32'd0);
    checkOutput("mid_rst_mispred", 32'(mispredictCnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      checkOutput($sformatf("mid_rst_r%0d", i), 32'(sr1Out), 32'h0);
      checkOutput($sformatf("mid_rst_s%0d", 7 - i), 32'(sr2Out), 32'h0);
    end

    // three commits, one of them a mispredict
    applyStimulus(); valid = 1; loadRegfile = 1; destReg = 1; aluOut = 16'h0007;
    tick();
    applyStimulus(); valid = 1; isBr = 1; intr = 16'h0400; brPredict = 0; aluOut = 16'h0050;
    tick();
    applyStimulus(); valid = 1; loadRegfile = 1; destReg = 6; wbmuxSel = 2'd1; memData = 16'h00F0;
    tick();
    applyStimulus(); sr1 = 1; sr2 = 6;
    #1;
    checkOutput("cnt3_retired", retiredCnt, CntEn ? 32'd3 : 32'd0);
    checkOutput("cnt3_mispred", 32'(mispredictCnt), CntEn ? 32'd1 : 32'd0);
    checkOutput("cnt3_r1", 32'(sr1Out), 32'h0007);
    checkOutput("cnt3_r6", 32'(sr2Out), 32'h00F0);
    checkOutput("cnt3_redirect", 32'(redirectPc), 32'h0050);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: valid  in  1  MEM/WB register holds a live instruction.
REQ-004 SHALL have ports: stall  in  1  1 = pipeline advances (no stall), 0 = hold.
REQ-005 SHALL have ports: load_regfile, load_cc, is_br, brpredict  in  1 each  decoded controls carried from MEM/WB.
REQ-006 SHALL have ports: wbmux_sel  in  2  0 = alu_out, 1 = mem_data, 2 = pc_out, 3 = 16'h0.
REQ-007 SHALL have ports: alu_out, mem_data, pc_out, intr  in  16 each  MEM/WB payload; pc_out = PC+2.
REQ-008 SHALL have ports: destreg  in  3  destination register.
REQ-009 SHALL have ports: sr1, sr2  in  3  decode-stage read indices; sr1_out, sr2_out  out  16  read data.
REQ-010 SHALL have ports: cc_out  out  3  current {n,z,p}.
REQ-011 SHALL have ports: wb_we  out  1, wb_destreg  out  3, wb_data  out  16  forwarding tap.
REQ-012 SHALL have ports: flush  out  1, redirect_pc  out  16  registered mispredict redirect.
REQ-013 SHALL have ports: retired_cnt  out  32, mispredict_cnt  out  16  performance counters.

Function
REQ-014 SHALL compute wb_data from wbmux_sel combinationally, zero-latency.
REQ-015 SHALL define commit = valid & stall; no architectural state changes without commit.
REQ-016 SHALL write wb_data to regfile[destreg] (8 x 16) on commit & load_regfile.
REQ-017 SHALL drive wb_we = commit & load_regfile, with wb_destreg = destreg.
REQ-018 SHALL return the value being written when sr1/sr2 equals destreg during a write cycle (write-through bypass); otherwise the stored value.
REQ-019 SHALL load cc on commit & load_cc: n = wb_data[15]; z = (wb_data == 0); p = !n & !z; exactly one bit set.
REQ-020 SHALL resolve a branch on commit & is_br: taken = |(intr[11:9] & cc), using the cc value before this cycle's update.
REQ-021 SHALL flag a mispredict when taken != brpredict; target = taken ? alu_out : pc_out.
REQ-022 SHALL, on a mispredict, assert flush for exactly one cycle, the cycle after commit, with redirect_pc = target.
REQ-023 SHALL hold redirect_pc when flush is low; back-to-back mispredicts produce back-to-back flush pulses.
REQ-024 SHALL keep flush low and all state unchanged when stall = 0, even if valid = 1.
REQ-025 SHALL ignore valid = 0 entries entirely, including is_br and load bits.

Reset
REQ-026 SHALL, on reset, clear all regfile entries to 16'h0, set cc = 3'b010, flush = 0, redirect_pc = 16'h0, and both counters = 0.
REQ-027 SHALL give reset priority over a simultaneous commit: no write, no flush, and no count on that edge.
REQ-028 SHALL suppress, when reset is asserted the cycle after a mispredict commit, the pending flush (flush = 0).

Configuration
REQ-029 SHALL use macro WB_PERF_CNT_EN to compile the performance counters in or out.
REQ-030 SHALL, with the macro defined: increment retired_cnt on every commit (wraps at 2^32); increment mispredict_cnt on every mispredict (saturates at 16'hFFFF).
REQ-031 SHALL, with the macro undefined: tie retired_cnt and mispredict_cnt to 0 and instantiate no counter flops.

Verification
REQ-032 SHALL cover regfile write with bypass: commit load_regfile, destreg = 3, wbmux_sel = 1, mem_data = 16'h8001, sr1 = 3 in the same cycle -> sr1_out = 16'h8001 that cycle and after.
REQ-033 SHALL cover CC generation: load_cc with alu_out = 0 -> cc_out = 010; then 16'hFFFE -> 100; then 16'h0005 -> 001.
REQ-034 SHALL cover a mispredict: cc = 010, intr[11:9] = 010, brpredict = 0, alu_out = 16'h0040 -> next cycle flush = 1, redirect_pc = 16'h0040; following cycle flush = 0.
REQ-035 SHALL cover stall hold: valid = 1, stall = 0, load_regfile, destreg = 5 -> R5 unchanged, wb_we = 0, no flush, retired_cnt unchanged.
REQ-036 SHALL cover reset mid-operation: mispredict commit, then reset the next cycle -> flush = 0, cc = 010, all registers read 0.
REQ-037 SHALL cover counters (WB_PERF_CNT_EN defined): 3 commits including 1 mispredict -> retired_cnt = 3, mispredict_cnt = 1; undefined -> both 0.
